router_port_rx: RTL and testbench
=================================

# router_port_rx

Single-port packet receiver for the 16x16 router's output side. It attaches to one router output port (`dout` bit, `frameo_n`, `valido_n`), deserializes the LSB-first bit stream into bytes, and marks packet boundaries. It also reports framing errors and per-packet byte counts to the downstream sink or scoreboard logic. Sixteen instances cover the full router; it is the receiving counterpart of the per-port input serial protocol.

## Interface

Parameters:
- `LEN_W`, default 8: width of the per-packet byte counter `pkt_len`. The counter saturates at 2^LEN_W-1.

Ports:
- `clk`  in  1  single clock; all inputs are sampled on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `dout`  in  1  serial data bit from the router output port.
- `frameo_n`  in  1  active-low frame. Low for the whole packet; goes high in the same cycle as the last valid bit.
- `valido_n`  in  1  active-low bit-valid qualifier for `dout`.
- `byte_out`  out  8  assembled byte; bit 0 is the first received bit.
- `byte_valid`  out  1  one-cycle strobe; `byte_out` is valid while it is high.
- `byte_last`  out  1  high with `byte_valid` for the final byte of a packet.
- `pkt_done`  out  1  one-cycle strobe at the end of every packet, including aborted packets.
- `pkt_len`  out  LEN_W  bytes emitted for the packet; valid while `pkt_done` is high.
- `err_partial`  out  1  strobe with `pkt_done`: the final byte was incomplete and zero-padded.
- `err_proto`  out  1  one-cycle strobe on any protocol violation.
- `pkt_count`  out  16  count of completed packets, aborted ones included; wraps modulo 2^16.

## Operation

- Reset values: all outputs are 0. State is SYNC, and the bit counter, shift register and length counter are cleared. Reset is asynchronous and takes effect immediately, including mid-packet. Partially received data is discarded and no strobes are produced for it.
- FSM states:
  - SYNC: wait for `frameo_n`=1, then go to IDLE. This state keeps the block from locking onto a packet already in flight at reset release.
  - IDLE: if `frameo_n`=0, go to RECV. If `valido_n`=0 in that same cycle, that bit is captured as bit 0. If instead `valido_n`=0 while `frameo_n`=1, pulse `err_proto` and stay in IDLE.
  - RECV, on a cycle with `valido_n`=0: shift `dout` into position `bitcnt`[2:0], then increment `bitcnt`. When 8 bits are accumulated, emit a byte and increment `pkt_len`.
  - RECV, on a cycle with `valido_n`=1 and `frameo_n`=0: gap cycle; no change.
  - RECV, on a cycle with `frameo_n`=1 and `valido_n`=0 (normal end): capture the bit and emit the final byte with `byte_last`=1. If the bit count mod 8 is not 0, emit the partial byte with its upper bits zero and pulse `err_partial`. Pulse `pkt_done` and go to IDLE.
  - RECV, on a cycle with `frameo_n`=1 and `valido_n`=1 (abort, or an empty packet): pulse `err_proto` and `pkt_done`. Discard any buffered partial bits; bytes already emitted stand and no `byte_last` is issued. Go to IDLE.
- `pkt_len` counts emitted bytes, with the partial final byte counted as 1. It saturates at max and does not wrap. It is held when no packet is in progress and resets to 0 on entry to RECV.
- `pkt_count` increments once per `pkt_done`.
- No backpressure: every valid bit is accepted, and sinks must take `byte_valid` unconditionally.

## Timing

- Inputs are sampled at edge N. Resulting outputs are registered at edge N and visible during cycle N+1. Latency is 1 cycle from the 8th bit's sampling edge to the `byte_valid` cycle.
- Strobes `byte_valid`, `pkt_done`, `err_partial` and `err_proto` are high for exactly one cycle. `byte_out` and `byte_last` are held until the next `byte_valid`.
- `pkt_done`, `pkt_len`, `byte_last` and `err_partial` assert in the same cycle as the final `byte_valid`.
- Back-to-back packets are supported. The end-of-packet cycle, with `frameo_n`=1, suffices as the inter-frame gap, so `frameo_n`=0 on the next cycle starts a new packet.
- A one-bit packet gives `byte_out`=bit, `byte_last`=1, `err_partial`=1 and `pkt_len`=1.

## Test plan

- 8-bit packet 0xA5 sent LSB first, `frameo_n` high with bit 7 -> one `byte_valid` with 0xA5 and `byte_last`=1. `pkt_done` asserts with `pkt_len`=1; no error strobes; `pkt_count`=1.
- 24-bit packet with bytes 0x01, 0x80, 0xFF and 2-cycle `valido_n` gaps between bits -> three bytes in order, `byte_last` only on 0xFF, `pkt_len`=3.
- 12-bit packet carrying 0xABC -> 0xBC, then 0x0A with `byte_last`=1 and `err_partial`=1, `pkt_len`=2.
- Protocol violations:
  - `valido_n` low while idle -> `err_proto` pulse, no bytes emitted.
  - 11 bits sent, then `frameo_n` high with `valido_n` high -> one byte emitted with no `byte_last`, then `err_proto` and `pkt_done` with `pkt_len`=1.
- `reset` asserted after 5 bits and released with `frameo_n` still low -> all outputs are 0 and the remainder of that packet is ignored. After `frameo_n` goes high, the next packet 0x3C is received correctly.
- Two back-to-back packets 0x11 and 0x22 with no idle cycle between them -> both received, each with `pkt_done`; `pkt_count`=2.

Source files
------------

// File: rtl/router_port_rx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// router_port_rx_if : serial router output port plus byte/packet report bus
// Revision: 1.0
// ---------------------------------------------------------------------------
interface router_port_rx_if #(
  parameter int LEN_W = 8
);
  logic             dout;
  logic             frameo_n;
  logic             valido_n;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             byte_last;
  logic             pkt_done;
  logic [LEN_W-1:0] pkt_len;
  logic             err_partial;
  logic             err_proto;
  logic [15:0]      pkt_count;

  modport master (
    output dout, frameo_n, valido_n,
    input  byte_out, byte_valid, byte_last, pkt_done, pkt_len,
    input  err_partial, err_proto, pkt_count
  );

  modport slave (
    input  dout, frameo_n, valido_n,
    output byte_out, byte_valid, byte_last, pkt_done, pkt_len,
    output err_partial, err_proto, pkt_count
  );
endinterface
`default_nettype wire

// File: rtl/router_port_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// router_port_rx : deserializes one router output port into framed bytes
// Revision: 1.0
// ---------------------------------------------------------------------------
module router_port_rx #(
  parameter int LEN_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  router_port_rx_if.slave bus_io
);
  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    RECV = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_valid_q, byte_valid_d;
  logic             byte_last_q, byte_last_d;
  logic             pkt_done_q, pkt_done_d;
  logic             err_partial_q, err_partial_d;
  logic             err_proto_q, err_proto_d;
  logic [15:0]      pkt_count_q, pkt_count_d;

  logic [7:0]       w_byte;
  logic [LEN_W-1:0] w_len_inc;

  // Current accumulator with the incoming bit merged at its final position
  assign w_byte    = shreg_q | ({7'd0, bus_io.dout} << bitcnt_q);
  assign w_len_inc = (&pkt_len_q) ? pkt_len_q : pkt_len_q + LEN_W'(1);

  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    shreg_d       = shreg_q;
    pkt_len_d     = pkt_len_q;
    byte_out_d    = byte_out_q;
    byte_last_d   = byte_last_q;
    pkt_count_d   = pkt_count_q;
    byte_valid_d  = 1'b0;
    pkt_done_d    = 1'b0;
    err_partial_d = 1'b0;
    err_proto_d   = 1'b0;

    case (state_q)
      SYNC: begin
        if (bus_io.frameo_n) state_d = IDLE;
      end
      IDLE: begin
        if (!bus_io.frameo_n) begin
          state_d   = RECV;
          pkt_len_d = '0;
          bitcnt_d  = 3'd0;
          shreg_d   = 8'd0;
          if (!bus_io.valido_n) begin
            shreg_d  = {7'd0, bus_io.dout};
            bitcnt_d = 3'd1;
          end
        end else if (!bus_io.valido_n) begin
          err_proto_d = 1'b1;
        end
      end
      RECV: begin
        if (!bus_io.valido_n) begin
          if (bus_io.frameo_n) begin
            byte_out_d    = w_byte;
            byte_valid_d  = 1'b1;
            byte_last_d   = 1'b1;
            err_partial_d = (bitcnt_q != 3'd7);
            pkt_len_d     = w_len_inc;
            pkt_done_d    = 1'b1;
            pkt_count_d   = pkt_count_q + 16'd1;
            bitcnt_d      = 3'd0;
            shreg_d       = 8'd0;
            state_d       = IDLE;
          end else if (bitcnt_q == 3'd7) begin
            byte_out_d   = w_byte;
            byte_valid_d = 1'b1;
            byte_last_d  = 1'b0;
            pkt_len_d    = w_len_inc;
            bitcnt_d     = 3'd0;
            shreg_d      = 8'd0;
          end else begin
            shreg_d  = w_byte;
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else if (bus_io.frameo_n) begin
          // Frame dropped without a final bit: buffered bits are discarded
          err_proto_d = 1'b1;
          pkt_done_d  = 1'b1;
          pkt_count_d = pkt_count_q + 16'd1;
          bitcnt_d    = 3'd0;
          shreg_d     = 8'd0;
          state_d     = IDLE;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SYNC;
      bitcnt_q      <= 3'd0;
      shreg_q       <= 8'd0;
      pkt_len_q     <= '0;
      byte_out_q    <= 8'd0;
      byte_valid_q  <= 1'b0;
      byte_last_q   <= 1'b0;
      pkt_done_q    <= 1'b0;
      err_partial_q <= 1'b0;
      err_proto_q   <= 1'b0;
      pkt_count_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      shreg_q       <= shreg_d;
      pkt_len_q     <= pkt_len_d;
      byte_out_q    <= byte_out_d;
      byte_valid_q  <= byte_valid_d;
      byte_last_q   <= byte_last_d;
      pkt_done_q    <= pkt_done_d;
      err_partial_q <= err_partial_d;
      err_proto_q   <= err_proto_d;
      pkt_count_q   <= pkt_count_d;
    end
  end

  assign bus_io.byte_out    = byte_out_q;
  assign bus_io.byte_valid  = byte_valid_q;
  assign bus_io.byte_last   = byte_last_q;
  assign bus_io.pkt_done    = pkt_done_q;
  assign bus_io.pkt_len     = pkt_len_q;
  assign bus_io.err_partial = err_partial_q;
  assign bus_io.err_proto   = err_proto_q;
  assign bus_io.pkt_count   = pkt_count_q;

endmodule
`default_nettype wire

// File: tb/tb_router_port_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_router_port_rx : directed packet vectors against router_port_rx
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_router_port_rx;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  router_port_rx_if #(.LEN_W(8)) bus();
  router_port_rx #(.LEN_W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  typedef struct {
    int          nbits;
    logic [31:0] data;
    int          gap;
    bit          abort;
    int          exp_nb;
    logic [31:0] exp_bytes;
    int          exp_len;
    bit          exp_part;
    int          exp_proto;
  } vec_t;

  vec_t vecs[8];

  int n_pass  = 0;
  int n_total = 0;
  int exp_count = 0;

  // Output monitor, sampled on the falling edge
  int         n_bytes = 0;
  int         n_done  = 0;
  int         n_proto = 0;
  int         n_stray = 0;
  logic [7:0] mb[1024];
  logic       ml[1024];
  logic [7:0] last_len;
  logic       last_part;
  logic       last_done_bv;

  always @(negedge clk) begin
    if (bus.byte_valid === 1'b1) begin
      if (n_bytes < 1024) begin
        mb[n_bytes] = bus.byte_out;
        ml[n_bytes] = bus.byte_last;
      end
      n_bytes++;
    end
    if (bus.pkt_done === 1'b1) begin
      n_done++;
      last_len     = bus.pkt_len;
      last_part    = bus.err_partial;
      last_done_bv = bus.byte_valid;
    end
    if (bus.err_proto === 1'b1) n_proto++;
    if (bus.err_partial === 1'b1 && bus.pkt_done !== 1'b1) n_stray++;
  end

  task automatic check(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic cyc(input logic f, input logic v, input logic d);
    @(negedge clk);
    bus.frameo_n = f;
    bus.valido_n = v;
    bus.dout     = d;
  endtask

  task automatic send_pkt(input int nbits, input logic [31:0] data, input int gap,
                          input bit abort, input int tail);
    if (abort && nbits == 0) cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b1, 1'b0);
      cyc((i == nbits - 1 && !abort) ? 1'b1 : 1'b0, 1'b0, data[i]);
    end
    if (abort) cyc(1'b1, 1'b1, 1'b0);
    for (int t = 0; t < tail; t++) cyc(1'b1, 1'b1, 1'b0);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int bb, bd, bp;
    logic [7:0] eb;
    bb = n_bytes;
    bd = n_done;
    bp = n_proto;
    send_pkt(v.nbits, v.data, v.gap, v.abort, 2);
    exp_count++;
    check("byte count", n_bytes - bb, v.exp_nb);
    for (int k = 0; k < v.exp_nb; k++) begin
      eb = v.exp_bytes[8*k +: 8];
      check("byte_out", mb[bb+k], eb);
      check("byte_last", ml[bb+k], (!v.abort && k == v.exp_nb - 1) ? 1 : 0);
    end
    check("pkt_done count", n_done - bd, 1);
    check("pkt_len", last_len, v.exp_len);
    check("err_partial", last_part, v.exp_part);
    check("err_proto count", n_proto - bp, v.exp_proto);
    check("pkt_done with byte_valid", last_done_bv, v.abort ? 0 : 1);
    check("pkt_count", bus.pkt_count, exp_count);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    int bb, bd, bp;
    //        nbits data           gap abort nb bytes           len part proto
    vecs[0] = '{8,  32'h0000_00A5, 0, 1'b0, 1, 32'h0000_00A5, 1, 1'b0, 0};
    vecs[1] = '{24, 32'h00FF_8001, 2, 1'b0, 3, 32'h00FF_8001, 3, 1'b0, 0};
    vecs[2] = '{12, 32'h0000_0ABC, 0, 1'b0, 2, 32'h0000_0ABC, 2, 1'b1, 0};
    vecs[3] = '{11, 32'h0000_05C3, 0, 1'b1, 1, 32'h0000_00C3, 1, 1'b0, 1};
    vecs[4] = '{1,  32'h0000_0001, 1, 1'b0, 1, 32'h0000_0001, 1, 1'b1, 0};
    vecs[5] = '{9,  32'h0000_01FF, 0, 1'b0, 2, 32'h0000_01FF, 2, 1'b1, 0};
    vecs[6] = '{0,  32'h0000_0000, 0, 1'b1, 0, 32'h0000_0000, 0, 1'b0, 1};
    vecs[7] = '{16, 32'h0000_1234, 1, 1'b0, 2, 32'h0000_1234, 2, 1'b0, 0};

    reset        = 1'b1;
    bus.frameo_n = 1'b1;
    bus.valido_n = 1'b1;
    bus.dout     = 1'b0;
    #1;
    check("reset outputs", {bus.byte_out, bus.byte_valid, bus.byte_last, bus.pkt_done,
                            bus.pkt_len, bus.err_partial, bus.err_proto, bus.pkt_count}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);

    // Bit-valid while no frame is open
    bb = n_bytes; bd = n_done; bp = n_proto;
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    #1;
    check("idle violation err_proto", n_proto - bp, 1);
    check("idle violation bytes", n_bytes - bb, 0);
    check("idle violation pkt_done", n_done - bd, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset in the middle of a packet, released while the frame is still open
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid-packet reset outputs", {bus.byte_out, bus.byte_valid, bus.byte_last,
          bus.pkt_done, bus.pkt_len, bus.err_partial, bus.err_proto, bus.pkt_count}, 0);
    bb = n_bytes; bd = n_done; bp = n_proto;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    #1;
    exp_count = 0;
    check("ignored tail bytes", n_bytes - bb, 0);
    check("ignored tail pkt_done", n_done - bd, 0);
    check("ignored tail err_proto", n_proto - bp, 0);
    check("ignored tail pkt_count", bus.pkt_count, 0);
    run_vec('{8, 32'h0000_003C, 0, 1'b0, 1, 32'h0000_003C, 1, 1'b0, 0});

    // Back-to-back packets from a clean reset
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 1'b1, 1'b0);
    exp_count = 0;
    bb = n_bytes; bd = n_done; bp = n_proto;
    send_pkt(8, 32'h11, 0, 1'b0, 0);
    send_pkt(8, 32'h22, 0, 1'b0, 2);
    check("b2b byte count", n_bytes - bb, 2);
    check("b2b first byte", mb[bb], 8'h11);
    check("b2b first byte_last", ml[bb], 1);
    check("b2b second byte", mb[bb+1], 8'h22);
    check("b2b pkt_done count", n_done - bd, 2);
    check("b2b pkt_count", bus.pkt_count, 2);

    // 257-byte packet: pkt_len saturates at 255
    bb = n_bytes; bd = n_done;
    for (int i = 0; i < 2055; i++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    #1;
    check("long byte count", n_bytes - bb, 257);
    check("long pkt_len saturated", last_len, 255);
    check("long err_partial", last_part, 0);
    check("long pkt_count", bus.pkt_count, 3);
    check("err_partial outside pkt_done", n_stray, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
